alp_mulseq: RTL
===============

# alp_mulseq

Multiply-step sequencer that drives the opcode, shift and clock-enable inputs of a stacked DC608 ALP datapath, and reads the datapath's Q-shift and flag outputs. On `start_h` it loads the operands and runs STEPS conditional add-and-shift cycles steered by the Q register LSB. For a signed operation with a negative multiplier, it then runs one subtract fix-up cycle. It sits between the microsequencer and the ALP slices and replaces per-step microcode for MUL.

## Interface
- STEPS, 32: number of add/shift steps; counter width is clog2(STEPS).
- OPC_NOP, 10'h000: opc_h value driven while idle or done.
- OPC_LOAD, 10'h0C3: load D from M bus and Q from R bus.
- OPC_ADDSH, 10'h1A6: A+D, shift the result and Q right.
- OPC_PASSSH, 10'h186: pass A, shift it and Q right.
- OPC_SUBFIX, 10'h12C: A−D without shift.
- SHF_RIGHT, 2'b10: shf_h code driven during step cycles; 2'b00 is driven otherwise.

Ports:
- clk_h  in  1  sequencer clock; also the qdck/lck source domain.
- rst_l  in  1  asynchronous active-low reset.
- start_h  in  1  begin an operation; sampled only in IDLE or DONE.
- signed_h  in  1  signed multiply; captured with start_h.
- abort_h  in  1  cancel the operation; effective only while busy.
- q_lsb_h  in  1  Q bit 0 from the least-significant slice `q_sio_l0` line.
- q_msb_h  in  1  Q bit 31 from the most-significant slice.
- v_in_h  in  1  ALP `v_out` of the top slice.
- wmuxz_l  in  1  wired-AND zero flag of WMUX, active low.
- opc_l  out  10  ALP opcode, active low; equals ~opc_h.
- shf_h  out  2  ALP shift control.
- carry_in_h  out  1  carry into the least-significant slice.
- qd_en_h  out  1  gate enable for qdck_l.
- lck_en_h  out  1  gate enable for lck_l.
- busy_h  out  1  high in LOAD, STEP and FIX.
- done_h  out  1  one-cycle completion pulse.
- v_h, z_h  out  1 each  captured overflow and zero flags.

## Operation
- States: IDLE, LOAD, STEP, FIX, DONE.
- IDLE:
  - opc_h=OPC_NOP, shf_h=00, all enables 0.
  - start_h → LOAD, capturing signed_h.
- LOAD:
  - opc_h=OPC_LOAD, qd_en_h=lck_en_h=1.
  - Loads cnt=STEPS−1, then → STEP.
- STEP:
  - The opcode is combinational from q_lsb_h in the current cycle: 1 → OPC_ADDSH, 0 → OPC_PASSSH.
  - shf_h=SHF_RIGHT, carry_in_h=0, both enables 1.
  - In the first STEP cycle (cnt=STEPS−1), neg is captured as q_msb_h & signed.
  - cnt decrements each cycle. At cnt=0: → FIX if neg, else → DONE.
- FIX:
  - opc_h=OPC_SUBFIX, shf_h=00, carry_in_h=1, both enables 1.
  - Then → DONE.
- DONE:
  - opc_h=OPC_NOP, done_h=1.
  - start_h → LOAD (back-to-back), else → IDLE.
- Flags: on the last operating cycle (the final STEP when FIX is not entered, or FIX), register v_h ← v_in_h and z_h ← ~wmuxz_l at the clock edge. v_h and z_h hold until the next completion.
- abort_h while busy:
  - → IDLE at the next edge, with no done_h pulse and flags unchanged.
  - Abort has priority over any state transition.
  - In IDLE or DONE, abort_h is ignored, and start_h wins.
- start_h while busy is ignored; it is not queued.

## Timing
- Reset (async assert, synchronous release): state=IDLE, cnt=0, neg=0.
  - opc_l=~OPC_NOP, shf_h=00, carry_in_h=0.
  - qd_en_h=lck_en_h=busy_h=done_h=0, v_h=z_h=0.
- Reset asserted mid-operation forces IDLE immediately; no done_h.
- start_h sampled at edge E0: LOAD occupies cycle 1 and STEP occupies cycles 2..STEPS+1.
  - Without fix-up: done_h in cycle STEPS+2.
  - With fix-up: FIX in cycle STEPS+2 and done_h in cycle STEPS+3.
- Opcode select: q_lsb_h must be settled before the shifting edge of that step cycle.
- Enables are combinational from state and go low in the DONE cycle.
- The flag inputs are sampled on the same edge that leaves the final operating state.

## Test plan
- STEPS=4, unsigned, Q loaded with 4'b0101:
  - The step opcode sequence is ADDSH, PASSSH, ADDSH, PASSSH, driven with q_lsb_h pattern 1,0,1,0.
  - done_h appears in cycle 6, there is no FIX cycle, and busy_h is high in cycles 1–5.
- STEPS=4, signed_h=1, q_msb_h=1 in the first STEP cycle:
  - FIX occurs in cycle 6 with carry_in_h=1 and opc_l=~10'h12C.
  - done_h appears in cycle 7.
- Signed, q_msb_h=0: FIX is skipped and done_h appears in cycle 6.
- Back-to-back: start_h held through the DONE cycle → LOAD on the next cycle, with a single done_h pulse per operation.
- abort_h in the 2nd STEP cycle:
  - IDLE follows at the next edge with opc_l=~OPC_NOP.
  - There is no done_h, and v_h/z_h keep their prior values.
  - rst_l pulsed low mid-STEP gives every output its reset value asynchronously.
- Flags: v_in_h=1 and wmuxz_l=0 in the last step → after DONE, v_h=1, z_h=1, and both hold until the next completion.

Source files
------------

// File: rtl/alp_mulseq.sv
// Multiply-step sequencer for a stacked DC608 ALP datapath: drives opcode, shift and
// clock enables through load, conditional add/shift steps and an optional signed fix-up.
module alp_mulseq #(
    parameter int unsigned STEPS      = 32,
    parameter logic [9:0]  OPC_NOP    = 10'h000,
    parameter logic [9:0]  OPC_LOAD   = 10'h0C3,
    parameter logic [9:0]  OPC_ADDSH  = 10'h1A6,
    parameter logic [9:0]  OPC_PASSSH = 10'h186,
    parameter logic [9:0]  OPC_SUBFIX = 10'h12C,
    parameter logic [1:0]  SHF_RIGHT  = 2'b10
) (
    input  logic       clk_h,
    input  logic       rst_l,
    input  logic       start_h,
    input  logic       signed_h,
    input  logic       abort_h,
    input  logic       q_lsb_h,
    input  logic       q_msb_h,
    input  logic       v_in_h,
    input  logic       wmuxz_l,
    output logic [9:0] opc_l,
    output logic [1:0] shf_h,
    output logic       carry_in_h,
    output logic       qd_en_h,
    output logic       lck_en_h,
    output logic       busy_h,
    output logic       done_h,
    output logic       v_h,
    output logic       z_h
);

    localparam int unsigned CW = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CW-1:0] CNT_TOP = CW'(STEPS - 1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_STEP = 3'd2;
    localparam logic [2:0] S_FIX  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          neg_q, neg_d;
    logic          sgn_q, sgn_d;
    logic          v_q, v_d;
    logic          z_q, z_d;
    logic          flag_cap;
    logic [9:0]    opc_h;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        neg_d      = neg_q;
        sgn_d      = sgn_q;
        v_d        = v_q;
        z_d        = z_q;
        flag_cap   = 1'b0;
        opc_h      = OPC_NOP;
        shf_h      = 2'b00;
        carry_in_h = 1'b0;
        qd_en_h    = 1'b0;
        lck_en_h   = 1'b0;
        busy_h     = 1'b0;
        done_h     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_h) begin
                    state_d = S_LOAD;
                    sgn_d   = signed_h;
                end
            end
            S_LOAD: begin
                opc_h    = OPC_LOAD;
                qd_en_h  = 1'b1;
                lck_en_h = 1'b1;
                busy_h   = 1'b1;
                cnt_d    = CNT_TOP;
                state_d  = S_STEP;
            end
            S_STEP: begin
                opc_h    = q_lsb_h ? OPC_ADDSH : OPC_PASSSH;
                shf_h    = SHF_RIGHT;
                qd_en_h  = 1'b1;
                lck_en_h = 1'b1;
                busy_h   = 1'b1;
                // neg_d is used for the exit decision so a single-step run sees it too
                if (cnt_q == CNT_TOP) neg_d = q_msb_h & sgn_q;
                if (cnt_q == '0) begin
                    if (neg_d) begin
                        state_d = S_FIX;
                    end else begin
                        state_d  = S_DONE;
                        flag_cap = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_FIX: begin
                opc_h      = OPC_SUBFIX;
                carry_in_h = 1'b1;
                qd_en_h    = 1'b1;
                lck_en_h   = 1'b1;
                busy_h     = 1'b1;
                flag_cap   = 1'b1;
                state_d    = S_DONE;
            end
            S_DONE: begin
                done_h = 1'b1;
                if (start_h) begin
                    state_d = S_LOAD;
                    sgn_d   = signed_h;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (abort_h && busy_h) begin
            state_d  = S_IDLE;
            flag_cap = 1'b0;
        end

        if (flag_cap) begin
            v_d = v_in_h;
            z_d = ~wmuxz_l;
        end
    end

    always_ff @(posedge clk_h or negedge rst_l) begin
        if (!rst_l) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
            sgn_q   <= 1'b0;
            v_q     <= 1'b0;
            z_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            neg_q   <= neg_d;
            sgn_q   <= sgn_d;
            v_q     <= v_d;
            z_q     <= z_d;
        end
    end

    assign opc_l = ~opc_h;
    assign v_h   = v_q;
    assign z_h   = z_q;

endmodule
